gate_truth_table_sequencer: RTL and testbench
=============================================

Name: gate_truth_table_sequencer

Overview:
- Stimulus-and-capture stage placed directly upstream of the two-input logic-gate block.
- Drives the gate block's a/b inputs through all four input combinations and waits a settle time per combination.
- Captures the seven gate outputs into a 28-bit truth-table register and compares each against an internally computed expected value.
- Reports done, pass, and a per-gate mismatch mask, so a board button press produces a complete self-check of the gate block.

Parameters:
- SETTLE_CYCLES, 4, clocks each input combination is held before capture; legal range ≥1, values <1 are treated as 1.
- SYNC_STAGES, 2, flip-flop depth of the start_in synchroniser; legal range ≥2.

Ports:
- clk_in  input  1  single clock; all flops rising-edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- start_in  input  1  asynchronous start request (board button).
- y_not_in, y_and_in, y_or_in, y_xor_in, y_nand_in, y_nor_in, y_xnor_in  input  1 each  outputs of the gate block.
- a_out  output  1  drives the gate block's a input.
- b_out  output  1  drives the gate block's b input.
- row_idx_out  output  2  current row, {a,b}.
- busy_out  output  1  high while a sequence runs.
- done_out  output  1  high from sequence completion until the next start.
- pass_out  output  1  valid when done_out=1; 1 means no mismatch.
- table_out  output  28  captured truth table.
- mismatch_out  output  7  per-gate sticky mismatch flags.

Behaviour:
- Reset (asynchronous, active-low): every output goes to 0.
  - FSM enters IDLE.
  - Synchroniser flops and the edge-detect flop clear to 0.
  - A reset asserted mid-sequence abandons the sequence; no partial results are kept.
- Start detection:
  - start_in passes through a SYNC_STAGES flop chain, then a rising-edge detector, giving a one-clock internal start pulse.
  - A start_in held high across reset release counts as one rising edge.
- FSM states: IDLE, SETTLE, CAPTURE, DONE.
- IDLE or DONE + start pulse:
  - Clear table_out, mismatch_out, done_out and pass_out.
  - Set row=0 and load the settle counter.
  - Next state is SETTLE with busy_out=1.
- Start pulse in SETTLE or CAPTURE: ignored.
- SETTLE:
  - a_out=row[1], b_out=row[0], both registered.
  - Stay exactly SETTLE_CYCLES clocks, then go to CAPTURE.
- CAPTURE (exactly 1 clock):
  - Write the sampled inputs to table_out[row*7 +: 7].
  - Bit order within each row: bit0 not, 1 and, 2 or, 3 xor, 4 nand, 5 nor, 6 xnor.
  - Compare against expected values: ~a, a&b, a|b, a^b, ~(a&b), ~(a|b), ~(a^b).
  - OR any difference into mismatch_out (sticky per gate).
  - If row<3: increment row and go to SETTLE.
  - If row==3: go to DONE.
- DONE:
  - busy_out=0, done_out=1, pass_out=(mismatch_out==0).
  - a_out, b_out and row_idx_out return to 0.
  - table_out and mismatch_out hold until the next start pulse.
- Latency:
  - The internal start pulse occurs in cycle T.
  - The first SETTLE cycle is T+1.
  - done_out rises at T+1+4*(SETTLE_CYCLES+1): T+21 with defaults.
  - From a start_in edge, add SYNC_STAGES+1 clocks.
- Row counter: 2 bits, with no wrap-around beyond row 3. The transition to DONE is taken from row 3.
- busy_out and done_out are never both 1.

Test Plan:
1. Reset, then a correct gate model, start pulse → a/b sequence 00,01,10,11, each held 4 clocks; done_out at T+21; table_out=28'h8C70EF1; mismatch_out=0; pass_out=1.
2. y_and_in stuck at 1 → table_out=28'h8C78FF3, mismatch_out=7'b0000010, pass_out=0.
3. Start pulse during row 2 SETTLE → ignored; timing and results identical to scenario 1.
4. rst_n_in low during row 1 CAPTURE → all outputs 0 immediately, without waiting for a clock edge; FSM IDLE. After release, a fresh start gives the scenario 1 result.
5. Second start while in DONE after a failing run (scenario 2) → table, mismatch and done clear in the next cycle. With the correct model the rerun reports pass_out=1.
6. SETTLE_CYCLES=1 → done at T+9; a start_in glitch shorter than one clock is either missed or counted once, never twice.

Source files
------------

// File: rtl/gate_truth_table_sequencer.sv
// Gate truth-table sequencer: walks a/b through all four rows,
// captures the seven gate outputs and checks them against a reference.
`timescale 1ns/1ps

module gate_truth_table_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        y_not_in,
    input  logic        y_and_in,
    input  logic        y_or_in,
    input  logic        y_xor_in,
    input  logic        y_nand_in,
    input  logic        y_nor_in,
    input  logic        y_xnor_in,
    output logic        a_out,
    output logic        b_out,
    output logic [1:0]  row_idx_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        pass_out,
    output logic [27:0] table_out,
    output logic [6:0]  mismatch_out
);

    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int SYNC_EFF   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CW         = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [SYNC_EFF-1:0] sync;
    logic            sync_prev;
    logic            start_pulse;
    logic [CW-1:0]   cnt;
    logic [1:0]      row;
    logic [1:0]      row_inc;
    logic [6:0]      sample;
    logic [6:0]      expect_v;
    logic            launch;
    logic            capture;

    // Synchronise the button and remember the last synced level for edge detect
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync      <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_EFF-2:0], start_in};
            sync_prev <= sync[SYNC_EFF-1];
        end
    end

    assign start_pulse = sync[SYNC_EFF-1] & ~sync_prev;

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_next;
    end

    // Next-state logic and per-cycle strobes for the datapath
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start_pulse) begin
                    launch     = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) state_next = CAPTURE;
            end
            CAPTURE: begin
                capture    = 1'b1;
                state_next = (row == 2'd3) ? DONE : SETTLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign sample   = {y_xnor_in, y_nor_in, y_nand_in, y_xor_in,
                       y_or_in, y_and_in, y_not_in};
    assign expect_v = {~(a_out ^ b_out), ~(a_out | b_out), ~(a_out & b_out),
                       a_out ^ b_out, a_out | b_out, a_out & b_out, ~a_out};
    assign row_inc  = row + 2'd1;

    // Row stepping, settle timing, capture and sticky mismatch accumulation
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt          <= '0;
            row          <= 2'd0;
            a_out        <= 1'b0;
            b_out        <= 1'b0;
            table_out    <= '0;
            mismatch_out <= '0;
        end else if (launch) begin
            cnt          <= CNT_LOAD;
            row          <= 2'd0;
            a_out        <= 1'b0;
            b_out        <= 1'b0;
            table_out    <= '0;
            mismatch_out <= '0;
        end else if (state == SETTLE) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
        end else if (capture) begin
            table_out[5'(row) * 5'd7 +: 7] <= sample;
            mismatch_out <= mismatch_out | (sample ^ expect_v);
            cnt          <= CNT_LOAD;
            if (row != 2'd3) begin
                row   <= row_inc;
                a_out <= row_inc[1];
                b_out <= row_inc[0];
            end else begin
                row   <= 2'd0;
                a_out <= 1'b0;
                b_out <= 1'b0;
            end
        end
    end

    assign row_idx_out = row;
    assign busy_out    = (state == SETTLE) || (state == CAPTURE);
    assign done_out    = (state == DONE);
    assign pass_out    = done_out && (mismatch_out == '0);

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Directed bench for the gate truth-table sequencer: two instances,
// default settle time and SETTLE_CYCLES=1, each fed by a gate model.
`timescale 1ns/1ps

module tb_gate_truth_table_sequencer;

    localparam logic [27:0] GOOD_TAB = 28'h8C70EF1;
    localparam logic [27:0] BAD_TAB  = 28'h8C78FF3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        stuck_and0 = 1'b0;

    logic        a0, b0, busy0, done0, pass0;
    logic [1:0]  row0;
    logic [27:0] tab0;
    logic [6:0]  mm0;
    logic [6:0]  y0;

    logic        a1, b1, busy1, done1, pass1;
    logic [1:0]  row1;
    logic [27:0] tab1;
    logic [6:0]  mm1;
    logic [6:0]  y1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Reference gate block, with an optional stuck-at-1 AND output
    assign y0 = {~(a0 ^ b0), ~(a0 | b0), ~(a0 & b0), a0 ^ b0,
                 a0 | b0, stuck_and0 ? 1'b1 : (a0 & b0), ~a0};
    assign y1 = {~(a1 ^ b1), ~(a1 | b1), ~(a1 & b1), a1 ^ b1,
                 a1 | b1, a1 & b1, ~a1};

    gate_truth_table_sequencer dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start0),
        .y_not_in(y0[0]), .y_and_in(y0[1]), .y_or_in(y0[2]),
        .y_xor_in(y0[3]), .y_nand_in(y0[4]), .y_nor_in(y0[5]),
        .y_xnor_in(y0[6]),
        .a_out(a0), .b_out(b0), .row_idx_out(row0),
        .busy_out(busy0), .done_out(done0), .pass_out(pass0),
        .table_out(tab0), .mismatch_out(mm0)
    );

    gate_truth_table_sequencer #(.SETTLE_CYCLES(1), .SYNC_STAGES(2)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start1),
        .y_not_in(y1[0]), .y_and_in(y1[1]), .y_or_in(y1[2]),
        .y_xor_in(y1[3]), .y_nand_in(y1[4]), .y_nor_in(y1[5]),
        .y_xnor_in(y1[6]),
        .a_out(a1), .b_out(b1), .row_idx_out(row1),
        .busy_out(busy1), .done_out(done1), .pass_out(pass1),
        .table_out(tab1), .mismatch_out(mm1)
    );

    // Start dut and return the posedge count (1 = first edge after
    // start_in rises) at which done_out is first seen; optional second
    // start request raised after cycle inject_at. Returns 999 on timeout.
    task automatic run0(input int inject_at, output int done_at);
        done_at = 999;
        @(negedge clk);
        start0 = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) start0 = 1'b0;
            if (inject_at > 0 && n == inject_at) start0 = 1'b1;
            if (inject_at > 0 && n == inject_at + 3) start0 = 1'b0;
            if (n > 3 && done0) begin
                done_at = n;
                break;
            end
        end
        start0 = 1'b0;
    endtask

    task automatic run1(output int done_at);
        done_at = 999;
        @(negedge clk);
        start1 = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) start1 = 1'b0;
            if (n > 3 && done1) begin
                done_at = n;
                break;
            end
        end
        start1 = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({a0, b0, row0, busy0, done0, pass0, tab0, mm0} !== 42'd0) begin
            fails++;
            $display("FAIL reset_outputs: got a=%b b=%b row=%0d busy=%b done=%b pass=%b tab=%h mm=%b, want all 0",
                     a0, b0, row0, busy0, done0, pass0, tab0, mm0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy0, done0);
        end
    endtask

    task automatic test_correct();
        int done_at;
        int r;
        done_at = 999;
        stuck_and0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) start0 = 1'b0;
            if (n >= 3 && n <= 22) begin
                r = (n - 3) / 5;
                tests++;
                if ({a0, b0} !== 2'(r) || row0 !== 2'(r) || busy0 !== 1'b1) begin
                    fails++;
                    $display("FAIL row_seq cyc %0d: a=%b b=%b row=%0d busy=%b, want row %0d busy 1",
                             n, a0, b0, row0, busy0, r);
                end
            end
            if (busy0 && done0) begin
                tests++;
                fails++;
                $display("FAIL busy_done_both cyc %0d: busy=1 done=1, want not both", n);
            end
            if (n > 3 && done0) begin
                done_at = n;
                break;
            end
        end
        tests++;
        if (done_at !== 23) begin
            fails++;
            $display("FAIL correct_latency: done at edge %0d, want 23", done_at);
        end
        tests++;
        if (tab0 !== GOOD_TAB || mm0 !== 7'd0 || pass0 !== 1'b1) begin
            fails++;
            $display("FAIL correct_result: tab=%h mm=%b pass=%b, want %h 0 1",
                     tab0, mm0, pass0, GOOD_TAB);
        end
        tests++;
        if ({a0, b0, row0, busy0} !== 5'd0) begin
            fails++;
            $display("FAIL done_idle_outputs: a=%b b=%b row=%0d busy=%b, want 0",
                     a0, b0, row0, busy0);
        end
    endtask

    task automatic test_stuck_and();
        int d;
        stuck_and0 = 1'b1;
        run0(0, d);
        tests++;
        if (d !== 23) begin
            fails++;
            $display("FAIL stuck_latency: done at edge %0d, want 23", d);
        end
        tests++;
        if (tab0 !== BAD_TAB || mm0 !== 7'b0000010 || pass0 !== 1'b0) begin
            fails++;
            $display("FAIL stuck_result: tab=%h mm=%b pass=%b, want %h 0000010 0",
                     tab0, mm0, pass0, BAD_TAB);
        end
    endtask

    task automatic test_restart_from_done();
        int done_at;
        done_at = 999;
        stuck_and0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) begin
                tests++;
                if (done0 !== 1'b1 || mm0 !== 7'b0000010) begin
                    fails++;
                    $display("FAIL restart_hold: done=%b mm=%b, want 1 0000010", done0, mm0);
                end
            end
            if (n == 3) begin
                start0 = 1'b0;
                tests++;
                if (done0 !== 1'b0 || tab0 !== 28'd0 || mm0 !== 7'd0 || busy0 !== 1'b1) begin
                    fails++;
                    $display("FAIL restart_clear: done=%b tab=%h mm=%b busy=%b, want 0 0 0 1",
                             done0, tab0, mm0, busy0);
                end
            end
            if (n > 3 && done0) begin
                done_at = n;
                break;
            end
        end
        tests++;
        if (done_at !== 23 || pass0 !== 1'b1 || tab0 !== GOOD_TAB) begin
            fails++;
            $display("FAIL restart_result: done at %0d pass=%b tab=%h, want 23 1 %h",
                     done_at, pass0, tab0, GOOD_TAB);
        end
    endtask

    task automatic test_start_ignored();
        int d;
        run0(14, d);
        tests++;
        if (d !== 23) begin
            fails++;
            $display("FAIL ignore_latency: done at edge %0d, want 23", d);
        end
        tests++;
        if (tab0 !== GOOD_TAB || mm0 !== 7'd0 || pass0 !== 1'b1) begin
            fails++;
            $display("FAIL ignore_result: tab=%h mm=%b pass=%b, want %h 0 1",
                     tab0, mm0, pass0, GOOD_TAB);
        end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (done0 !== 1'b1 || busy0 !== 1'b0) begin
            fails++;
            $display("FAIL ignore_no_rerun: done=%b busy=%b, want 1 0", done0, busy0);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        @(negedge clk);
        start0 = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) start0 = 1'b0;
        end
        tests++;
        if (row0 !== 2'd1 || busy0 !== 1'b1) begin
            fails++;
            $display("FAIL mid_position: row=%0d busy=%b, want 1 1", row0, busy0);
        end
        rst_n = 1'b0;
        #2;
        tests++;
        if ({a0, b0, row0, busy0, done0, pass0, tab0, mm0} !== 42'd0) begin
            fails++;
            $display("FAIL mid_async_reset: a=%b b=%b row=%0d busy=%b done=%b tab=%h mm=%b, want all 0",
                     a0, b0, row0, busy0, done0, tab0, mm0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || tab0 !== 28'd0) begin
            fails++;
            $display("FAIL mid_idle_after: busy=%b done=%b tab=%h, want 0 0 0",
                     busy0, done0, tab0);
        end
        run0(0, d);
        tests++;
        if (d !== 23 || tab0 !== GOOD_TAB || pass0 !== 1'b1) begin
            fails++;
            $display("FAIL mid_rerun: done at %0d tab=%h pass=%b, want 23 %h 1",
                     d, tab0, pass0, GOOD_TAB);
        end
    endtask

    task automatic test_settle_one();
        int d;
        int starts;
        logic prev;
        run1(d);
        tests++;
        if (d !== 11) begin
            fails++;
            $display("FAIL s1_latency: done at edge %0d, want 11", d);
        end
        tests++;
        if (tab1 !== GOOD_TAB || mm1 !== 7'd0 || pass1 !== 1'b1) begin
            fails++;
            $display("FAIL s1_result: tab=%h mm=%b pass=%b, want %h 0 1",
                     tab1, mm1, pass1, GOOD_TAB);
        end
        // glitch spanning a rising edge, then one between edges
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            if (g == 0) begin
                #4 start1 = 1'b1;
                #2 start1 = 1'b0;
            end else begin
                #1 start1 = 1'b1;
                #2 start1 = 1'b0;
            end
            starts = 0;
            prev = busy1;
            for (int n = 0; n < 30; n++) begin
                @(posedge clk);
                #1;
                if (busy1 && !prev) starts++;
                prev = busy1;
            end
            tests++;
            if (starts > 1 || done1 !== 1'b1 || busy1 !== 1'b0) begin
                fails++;
                $display("FAIL s1_glitch%0d: starts=%0d done=%b busy=%b, want <=1 1 0",
                         g, starts, done1, busy1);
            end
        end
        tests++;
        if (tab1 !== GOOD_TAB || pass1 !== 1'b1) begin
            fails++;
            $display("FAIL s1_glitch_result: tab=%h pass=%b, want %h 1",
                     tab1, pass1, GOOD_TAB);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck_and();
        test_restart_from_done();
        test_start_ignored();
        test_reset_mid();
        test_settle_one();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
